usb_tx: RTL and testbench
=========================

Name: usb_tx

Overview:
USB full-speed packet transmitter on the device side of the endpoint; it drains the outgoing byte FIFO that the data buffer exposes.
- On a request from the protocol controller it serialises SYNC, PID, optional data payload, CRC16 and EOP onto the D+/D- lines.
- Line coding is NRZI with bit stuffing.
- It is the transmit counterpart of the USB RX path that fills the data buffer.

Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit time (minimum 2).
- MAX_PAYLOAD, 64, maximum data bytes per packet.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- tx_packet  input  3  request code: 0 idle, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL; 6 and 7 illegal.
- buffer_occupancy  input  7  bytes currently held in the data buffer.
- tx_packet_data  input  8  head byte of the data buffer; valid whenever occupancy > 0.
- get_tx_packet_data  output  1  one-cycle pop strobe to the data buffer.
- tx_transfer_active  output  1  high from packet start through the end of EOP.
- tx_error  output  1  request-error flag (see Optional Feature).
- dplus_out  output  1  D+ line drive.
- dminus_out  output  1  D- line drive.

Behaviour:
- Reset values: dplus_out=1, dminus_out=0 (idle J state); get_tx_packet_data=0; tx_transfer_active=0; tx_error=0; state IDLE.
- Reset is asynchronous. Asserting it mid-packet forces the J state and IDLE immediately; the partial packet is abandoned.
- States and order: IDLE -> SYNC -> PID -> DATA -> CRC -> EOP_SE0 -> EOP_J -> IDLE.
  - ACK, NAK and STALL go PID -> EOP_SE0 directly.
  - A DATA packet with zero length goes PID -> CRC.
- Start condition: tx_packet is sampled only in IDLE. A legal nonzero code at edge N causes:
  - payload length latched as buffer_occupancy, saturated to MAX_PAYLOAD;
  - tx_transfer_active=1 from cycle N+1;
  - first SYNC bit driven from cycle N+1.
- Changes on tx_packet while active are ignored.
- Bit timing: a bit counter runs 0..CLKS_PER_BIT-1, and each bit (including stuffed bits) is held for exactly CLKS_PER_BIT cycles.
- Serial order is LSB first throughout:
  - SYNC = 8'h80.
  - PID byte = {~pid[3:0], pid[3:0]}, with pid: DATA0=4'b0011, DATA1=4'b1011, ACK=4'b0010, NAK=4'b1010, STALL=4'b1110.
- Data fetch: at the cycle a new payload byte is loaded into the shift register, get_tx_packet_data=1 for exactly one cycle. The byte loaded is the tx_packet_data value in that cycle, and the buffer pops on that edge. One pop per payload byte, so a packet of length L produces exactly L pops.
- CRC16:
  - polynomial x^16+x^15+x^2+1, register initialised to 16'hFFFF at PID;
  - updated per payload data bit, with stuffed bits excluded;
  - the complement of the register is sent, bit 15 first.
  - A zero-length payload therefore sends 16 zero bits... of the complemented value 16'h0000... i.e. CRC bytes 16'h0000.
- NRZI encoding: a 0 bit toggles the J/K line state; a 1 bit holds it. K state is dplus=0, dminus=1.
- Bit stuffing:
  - a ones counter covers SYNC through the last CRC bit;
  - after six consecutive 1s a 0 is inserted and the counter is cleared;
  - a stuffed bit is also inserted after a sixth 1 that is the last CRC bit.
  - The counter is cleared in IDLE.
- EOP: SE0 (dplus=0, dminus=0) for 2 bit times, then J for 1 bit time, then IDLE with tx_transfer_active=0. A new request can be accepted on the very next edge.
- buffer_occupancy may change during a packet; only the latched length is used.

Optional Feature:
- Macro: USB_TX_ERROR_EN.
- Defined:
  - tx_error is set for one cycle and no packet is sent when a request is illegal: tx_packet=6 or 7, or a DATA request with buffer_occupancy > MAX_PAYLOAD.
  - tx_transfer_active stays 0 and the block stays in IDLE.
- Not defined:
  - tx_error is tied 0.
  - Codes 6 and 7 are ignored as idle.
  - Oversize payload lengths saturate to MAX_PAYLOAD.

Test Plan:
- Reset -> lines J (1,0), all strobes 0. Request ACK -> NRZI line pattern for SYNC 0x80 then PID 0xD2, then 2 bit times SE0 and 1 bit time J. Total 19 bit times = 152 clocks active.
- DATA0 with occupancy 0 -> SYNC, PID 0xC3, CRC 16'h0000, EOP. No get_tx_packet_data pulses.
- DATA1 with occupancy 2, bytes 0xFF,0xFF -> exactly 2 pop pulses. A stuffed 0 after every run of six 1s (two stuffs in payload). Decoded CRC complement matches the reference model.
- DATA0 with occupancy 64 of an incrementing pattern 0x00..0x3F -> 64 pops; the bit-exact stream matches the model including all stuffed bits.
- Assert n_rst mid-DATA byte -> lines immediately J and active=0. A following NAK request sends a clean packet.
- Macro defined: tx_packet=7 -> tx_error one-cycle pulse and no line activity. Occupancy 65 with DATA0 -> tx_error; without the macro -> 64 pops.

Source files
------------

// File: rtl/usb_tx.sv
// USB full-speed packet transmitter: SYNC, PID, payload, CRC16, EOP with NRZI and bit stuffing.
// Build option USB_TX_ERROR_EN: illegal or oversize requests raise tx_error and are dropped.
//
// state   | meaning
// IDLE    | line J, sampling tx_packet
// SYNC    | shifting out 8'h80
// PID     | shifting out {~pid, pid}
// DATA    | shifting out payload bytes popped from the buffer
// CRC     | shifting out complemented CRC16, bit 15 first
// EOP_SE0 | two bit times of SE0
// EOP_J   | one bit time of J, then back to IDLE
module usb_tx #(
   parameter int CLKS_PER_BIT = 8,
   parameter int MAX_PAYLOAD  = 64
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [2:0] tx_packet,
   input  logic [6:0] buffer_occupancy,
   input  logic [7:0] tx_packet_data,
   output logic       get_tx_packet_data,
   output logic       tx_transfer_active,
   output logic       tx_error,
   output logic       dplus_out,
   output logic       dminus_out
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int LW = $clog2(MAX_PAYLOAD + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_PAYLOAD);

   typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J} state_t;

   state_t        state;
   logic [CW-1:0] clk_cnt;
   logic [3:0]    bit_idx;
   logic [7:0]    sr;
   logic [3:0]    pid_r;
   logic          handshake;
   logic [LW-1:0] len;
   logic [LW-1:0] byte_cnt;
   logic [15:0]   crc;
   logic [2:0]    ones;

   logic [3:0]    req_pid;
   logic          req_legal;
   logic          req_data;
   logic          oversize;
   logic [LW-1:0] occ_sat;
   logic          start;
   logic          next_bit;
   logic          bit_state;
   logic          adv_eop;
   logic          stuff_now;
   logic          send_bit;
   logic [1:0]    line_nxt;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h8005 : 16'h0000);
   endfunction

   always_comb begin
      req_pid   = 4'b0000;
      req_legal = 1'b0;
      case (tx_packet)
         3'd1: begin req_pid = 4'b0011; req_legal = 1'b1; end
         3'd2: begin req_pid = 4'b1011; req_legal = 1'b1; end
         3'd3: begin req_pid = 4'b0010; req_legal = 1'b1; end
         3'd4: begin req_pid = 4'b1010; req_legal = 1'b1; end
         3'd5: begin req_pid = 4'b1110; req_legal = 1'b1; end
         default: ;
      endcase
   end

   assign req_data = (tx_packet == 3'd1) || (tx_packet == 3'd2);
   assign oversize = int'(buffer_occupancy) > MAX_PAYLOAD;
   assign occ_sat  = oversize ? LEN_MAX : LW'(buffer_occupancy);

`ifdef USB_TX_ERROR_EN
   logic req_bad;
   logic err_q;
   assign start    = req_legal && !(req_data && oversize);
   assign req_bad  = (tx_packet[2:1] == 2'b11) || (req_data && oversize);
   assign tx_error = err_q;
`else
   assign start    = req_legal;
   assign tx_error = 1'b0;
`endif

   // Bit that the next advance will put on the line (IDLE: first SYNC bit)
   always_comb begin
      next_bit = 1'b0;
      case (state)
         SYNC:    next_bit = (bit_idx == 4'd7) ? pid_r[0] : sr[1];
         PID:     next_bit = (bit_idx != 4'd7) ? sr[1] :
                             (len == '0) ? ~crc[15] : tx_packet_data[0];
         DATA:    next_bit = (bit_idx != 4'd7) ? sr[1] :
                             (byte_cnt == len) ? ~crc[15] : tx_packet_data[0];
         CRC:     next_bit = ~crc[4'd14 - bit_idx];
         default: next_bit = 1'b0;
      endcase
   end

   assign bit_state = (state == SYNC) || (state == PID) || (state == DATA) || (state == CRC);
   assign adv_eop   = ((state == PID) && (bit_idx == 4'd7) && handshake) ||
                      ((state == CRC) && (bit_idx == 4'd15));
   assign stuff_now = bit_state && (ones == 3'd6);
   assign send_bit  = bit_state && !adv_eop;
   assign line_nxt  = next_bit ? {dplus_out, dminus_out} : {~dplus_out, ~dminus_out};

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state              <= IDLE;
         clk_cnt            <= '0;
         bit_idx            <= '0;
         sr                 <= '0;
         pid_r              <= '0;
         handshake          <= 1'b0;
         len                <= '0;
         byte_cnt           <= '0;
         crc                <= '0;
         ones               <= '0;
         get_tx_packet_data <= 1'b0;
         tx_transfer_active <= 1'b0;
         dplus_out          <= 1'b1;
         dminus_out         <= 1'b0;
`ifdef USB_TX_ERROR_EN
         err_q              <= 1'b0;
`endif
      end else begin
         get_tx_packet_data <= 1'b0;
`ifdef USB_TX_ERROR_EN
         err_q              <= 1'b0;
`endif
         if (state == IDLE) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            ones    <= '0;
            if (start) begin
               state                   <= SYNC;
               tx_transfer_active      <= 1'b1;
               sr                      <= 8'h80;
               pid_r                   <= req_pid;
               handshake               <= !req_data;
               len                     <= occ_sat;
               {dplus_out, dminus_out} <= line_nxt;
            end
`ifdef USB_TX_ERROR_EN
            else if (req_bad) begin
               err_q <= 1'b1;
            end
`endif
         end else if (clk_cnt != CNT_LAST) begin
            clk_cnt <= clk_cnt + CW'(1);
         end else begin
            clk_cnt <= '0;
            if (stuff_now) begin
               // Stuffed zero: line toggles, packet position does not move
               {dplus_out, dminus_out} <= {~dplus_out, ~dminus_out};
               ones                    <= '0;
            end else begin
               if (send_bit) begin
                  {dplus_out, dminus_out} <= line_nxt;
                  ones                    <= next_bit ? ones + 3'd1 : 3'd0;
               end
               case (state)
                  SYNC: begin
                     if (bit_idx == 4'd7) begin
                        state   <= PID;
                        sr      <= {~pid_r, pid_r};
                        bit_idx <= '0;
                        crc     <= 16'hFFFF;
                     end else begin
                        sr      <= sr >> 1;
                        bit_idx <= bit_idx + 4'd1;
                     end
                  end
                  PID, DATA: begin
                     if (bit_idx != 4'd7) begin
                        sr      <= sr >> 1;
                        bit_idx <= bit_idx + 4'd1;
                        if (state == DATA) crc <= crc_step(crc, sr[1]);
                     end else begin
                        bit_idx <= '0;
                        if (state == PID && handshake) begin
                           state                   <= EOP_SE0;
                           {dplus_out, dminus_out} <= 2'b00;
                        end else if ((state == PID && len == '0) ||
                                     (state == DATA && byte_cnt == len)) begin
                           state <= CRC;
                        end else begin
                           state              <= DATA;
                           sr                 <= tx_packet_data;
                           get_tx_packet_data <= 1'b1;
                           byte_cnt           <= (state == PID) ? LW'(1) : byte_cnt + LW'(1);
                           crc                <= crc_step(crc, tx_packet_data[0]);
                        end
                     end
                  end
                  CRC: begin
                     if (bit_idx == 4'd15) begin
                        state                   <= EOP_SE0;
                        bit_idx                 <= '0;
                        {dplus_out, dminus_out} <= 2'b00;
                     end else begin
                        bit_idx <= bit_idx + 4'd1;
                     end
                  end
                  EOP_SE0: begin
                     if (bit_idx == 4'd1) begin
                        state                   <= EOP_J;
                        bit_idx                 <= '0;
                        {dplus_out, dminus_out} <= 2'b10;
                     end else begin
                        bit_idx <= bit_idx + 4'd1;
                     end
                  end
                  EOP_J: begin
                     state              <= IDLE;
                     tx_transfer_active <= 1'b0;
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: decodes the NRZI line per bit and compares to a reference bit stream.
// Covers both builds of USB_TX_ERROR_EN.
module tb_usb_tx;
   localparam int CPB  = 8;
   localparam int MAXP = 64;

   logic       tb_clk = 1'b0;
   logic       n_rst;
   logic [2:0] tx_packet;
   logic [6:0] buffer_occupancy;
   logic [7:0] tx_packet_data;
   logic       get_tx_packet_data;
   logic       tx_transfer_active;
   logic       tx_error;
   logic       dplus_out;
   logic       dminus_out;

   always #5 tb_clk = ~tb_clk;

   usb_tx #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(MAXP)) dut (
      .clk                (tb_clk),
      .n_rst              (n_rst),
      .tx_packet          (tx_packet),
      .buffer_occupancy   (buffer_occupancy),
      .tx_packet_data     (tx_packet_data),
      .get_tx_packet_data (get_tx_packet_data),
      .tx_transfer_active (tx_transfer_active),
      .tx_error           (tx_error),
      .dplus_out          (dplus_out),
      .dminus_out         (dminus_out)
   );

   logic [7:0] fifo_mem [0:63];
   int pop_cnt  = 0;
   int act_cnt  = 0;
   int err_cnt  = 0;
   int pop_base = 0;
   int checks   = 0;
   int errors   = 0;
   bit exp_q[$];

   // Buffer head follows the number of pops seen since the packet began
   assign tx_packet_data = fifo_mem[6'(pop_cnt - pop_base)];

   always @(posedge tb_clk) begin
      #1;
      if (get_tx_packet_data) pop_cnt++;
      if (tx_transfer_active) act_cnt++;
      if (tx_error) err_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference stream: raw bits LSB first, reflected CRC16 (0xA001), then stuffing
   task automatic build_expected(input logic [3:0] pid, input int len, input bit hs);
      bit          raw[$];
      logic [7:0]  b;
      logic [15:0] c;
      int          ones;
      b = 8'h80;
      for (int i = 0; i < 8; i++) raw.push_back(b[i]);
      b = {~pid, pid};
      for (int i = 0; i < 8; i++) raw.push_back(b[i]);
      c = 16'hFFFF;
      if (!hs) begin
         for (int n = 0; n < len; n++) begin
            b = fifo_mem[n];
            for (int i = 0; i < 8; i++) begin
               raw.push_back(b[i]);
               if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
               else             c = c >> 1;
            end
         end
         c = ~c;
         for (int i = 0; i < 16; i++) raw.push_back(c[i]);
      end
      exp_q.delete();
      ones = 0;
      foreach (raw[k]) begin
         exp_q.push_back(raw[k]);
         if (raw[k]) ones++;
         else        ones = 0;
         if (ones == 6) begin
            exp_q.push_back(1'b0);
            ones = 0;
         end
      end
   endtask

   task automatic run_packet(input string tag, input logic [2:0] code, input logic [6:0] occ,
                             input logic [3:0] pid, input bit hs, input int exp_pops);
      logic [1:0] prev;
      logic [1:0] cur;
      int         nb;
      int         bad;
      int         a0;
      bit         got_eop;
      build_expected(pid, exp_pops, hs);
      @(negedge tb_clk);
      tx_packet        = code;
      buffer_occupancy = occ;
      pop_base         = pop_cnt;
      a0               = act_cnt;
      @(negedge tb_clk);
      tx_packet = 3'd0;
      repeat (CPB / 2 - 1) @(negedge tb_clk);
      prev    = 2'b10;
      nb      = 0;
      bad     = 0;
      got_eop = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         cur = {dplus_out, dminus_out};
         if (cur == 2'b00) begin
            got_eop = 1'b1;
            break;
         end
         if (k >= exp_q.size() || ((cur == prev) != exp_q[k])) bad++;
         prev = cur;
         nb++;
         repeat (CPB) @(negedge tb_clk);
      end
      chk({tag, " eop_seen"}, got_eop, 1);
      if (!got_eop) return;
      chk({tag, " nbits"}, nb, exp_q.size());
      chk({tag, " bit_errs"}, bad, 0);
      repeat (CPB) @(negedge tb_clk);
      chk({tag, " eop_se0_2"}, {dplus_out, dminus_out}, 2'b00);
      repeat (CPB) @(negedge tb_clk);
      chk({tag, " eop_j"}, {dplus_out, dminus_out}, 2'b10);
      repeat (CPB) @(negedge tb_clk);
      chk({tag, " idle_active"}, tx_transfer_active, 0);
      chk({tag, " pops"}, pop_cnt - pop_base, exp_pops);
      chk({tag, " active_clks"}, act_cnt - a0, (exp_q.size() + 3) * CPB);
   endtask

   initial begin
      int e0;
      int p0;
      n_rst            = 1'b0;
      tx_packet        = 3'd0;
      buffer_occupancy = 7'd0;
      for (int i = 0; i < 64; i++) fifo_mem[i] = 8'h00;
      repeat (3) @(negedge tb_clk);
      chk("rst dplus", dplus_out, 1);
      chk("rst dminus", dminus_out, 0);
      chk("rst get", get_tx_packet_data, 0);
      chk("rst active", tx_transfer_active, 0);
      chk("rst error", tx_error, 0);
      n_rst = 1'b1;

      run_packet("ack", 3'd3, 7'd0, 4'b0010, 1'b1, 0);
      run_packet("data0_empty", 3'd1, 7'd0, 4'b0011, 1'b0, 0);
      fifo_mem[0] = 8'hFF;
      fifo_mem[1] = 8'hFF;
      run_packet("data1_ff", 3'd2, 7'd2, 4'b1011, 1'b0, 2);
      for (int i = 0; i < 64; i++) fifo_mem[i] = 8'(i);
      run_packet("data0_64", 3'd1, 7'd64, 4'b0011, 1'b0, 64);

      // Reset in the middle of the first payload byte
      @(negedge tb_clk);
      tx_packet        = 3'd1;
      buffer_occupancy = 7'd4;
      @(negedge tb_clk);
      tx_packet = 3'd0;
      repeat (150) @(negedge tb_clk);
      chk("mid active", tx_transfer_active, 1);
      n_rst = 1'b0;
      #1;
      chk("async rst lines", {dplus_out, dminus_out}, 2'b10);
      chk("async rst active", tx_transfer_active, 0);
      @(negedge tb_clk);
      n_rst = 1'b1;
      run_packet("nak_after_rst", 3'd4, 7'd0, 4'b1010, 1'b1, 0);
      run_packet("stall", 3'd5, 7'd0, 4'b1110, 1'b1, 0);

`ifdef USB_TX_ERROR_EN
      e0 = err_cnt;
      @(negedge tb_clk);
      tx_packet = 3'd7;
      @(negedge tb_clk);
      tx_packet = 3'd0;
      chk("illegal err", tx_error, 1);
      chk("illegal active", tx_transfer_active, 0);
      @(negedge tb_clk);
      chk("illegal err clear", tx_error, 0);
      repeat (20) @(negedge tb_clk);
      chk("illegal lines", {dplus_out, dminus_out}, 2'b10);
      chk("illegal err count", err_cnt - e0, 1);

      e0 = err_cnt;
      p0 = pop_cnt;
      @(negedge tb_clk);
      tx_packet        = 3'd1;
      buffer_occupancy = 7'd65;
      @(negedge tb_clk);
      tx_packet = 3'd0;
      chk("oversize err", tx_error, 1);
      repeat (40) @(negedge tb_clk);
      chk("oversize active", tx_transfer_active, 0);
      chk("oversize err count", err_cnt - e0, 1);
      chk("oversize pops", pop_cnt - p0, 0);
      chk("oversize lines", {dplus_out, dminus_out}, 2'b10);
`else
      e0 = err_cnt;
      p0 = act_cnt;
      @(negedge tb_clk);
      tx_packet = 3'd7;
      repeat (20) @(negedge tb_clk);
      tx_packet = 3'd0;
      chk("code7 active clks", act_cnt - p0, 0);
      chk("code7 err count", err_cnt - e0, 0);
      chk("code7 lines", {dplus_out, dminus_out}, 2'b10);
      run_packet("data0_sat65", 3'd1, 7'd65, 4'b0011, 1'b0, 64);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
